// File: rtl/wbr_pkg.sv
// Shared definitions for the multi-chain IEEE 1500 wrapper boundary register.
package wbr_pkg;

    localparam int unsigned INSTR_W = 3;

    typedef enum logic [INSTR_W-1:0] {
        WS_BYPASS = 3'b000,
        WS_EXTEST = 3'b001,
        WS_INTEST = 3'b010,
        WS_SAFE   = 3'b011,
        WP_EXTEST = 3'b100,
        WP_INTEST = 3'b101
    } wbr_instr_e;

    // Cells per parallel chain; the last chain may be short or empty.
    function automatic int unsigned seg_len(input int unsigned n, input int unsigned chains);
        return (n + chains - 1) / chains;
    endfunction

endpackage

// File: rtl/wbr_cell_v2.sv
// One WBR boundary cell: shift/update flops and functional/test output mux.
// The safe-value override is present only when WBR_SAFE_STATE_EN is defined.
module wbr_cell_v2 (
    input  logic clk,
    input  logic arst,
    input  logic capture_en,
    input  logic shift_en,
    input  logic update_en,
    input  logic scan_in,
    input  logic func_in,
    input  logic test_sel,
`ifdef WBR_SAFE_STATE_EN
    input  logic safe_sel,
    input  logic safe_val,
`endif
    output logic s,
    output logic cell_out
);

    logic u;

    // Capture outranks shift; update always sees the pre-edge s.
    always_ff @(posedge clk) begin
        if (arst) begin
            s <= 1'b0;
            u <= 1'b0;
        end else begin
            if (capture_en)
                s <= func_in;
            else if (shift_en)
                s <= scan_in;
            if (update_en)
                u <= s;
        end
    end

    always_comb begin
        cell_out = test_sel ? u : func_in;
`ifdef WBR_SAFE_STATE_EN
        if (safe_sel)
            cell_out = safe_val;
`endif
    end

endmodule

// File: rtl/wbr_multichain_wrapper.sv
// IEEE 1500 WBR with instruction decoder, bypass bit and NUM_CHAINS parallel chains.
// Define WBR_SAFE_STATE_EN to implement WS_SAFE with the SAFE_VAL output muxes.
module wbr_multichain_wrapper
    import wbr_pkg::*;
#(
    parameter int unsigned NUM_IP     = 6,
    parameter int unsigned NUM_OP     = 6,
    parameter int unsigned NUM_CHAINS = 2,
    parameter logic [NUM_IP+NUM_OP-1:0] SAFE_VAL = '0
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [INSTR_W-1:0]    instr,
    input  logic                  capturewr,
    input  logic                  shiftwr,
    input  logic                  updatewr,
    input  logic                  wsi,
    output logic                  wso,
    input  logic [NUM_CHAINS-1:0] wpi,
    output logic [NUM_CHAINS-1:0] wpo,
    input  logic [NUM_IP-1:0]     wfi,
    output logic [NUM_IP-1:0]     ip_cfo,
    input  logic [NUM_OP-1:0]     op_cfi,
    output logic [NUM_OP-1:0]     wfo
);

    localparam int unsigned N = NUM_IP + NUM_OP;
    localparam int unsigned L = seg_len(N, NUM_CHAINS);

    wbr_instr_e mode;
    logic serial_m, par_m, active, ext_m, int_m;
    logic [N-1:0] s, sin, func, test_sel, cell_out;
    logic [NUM_CHAINS-1:0] wpo_par;
    logic byp;
`ifdef WBR_SAFE_STATE_EN
    logic safe_m;
`endif

    always_comb begin
        case (wbr_instr_e'(instr))
            WS_EXTEST: mode = WS_EXTEST;
            WS_INTEST: mode = WS_INTEST;
            WP_EXTEST: mode = WP_EXTEST;
            WP_INTEST: mode = WP_INTEST;
`ifdef WBR_SAFE_STATE_EN
            WS_SAFE:   mode = WS_SAFE;
`endif
            default:   mode = WS_BYPASS;
        endcase
    end

    assign serial_m = (mode == WS_EXTEST) || (mode == WS_INTEST);
    assign par_m    = (mode == WP_EXTEST) || (mode == WP_INTEST);
    assign active   = serial_m || par_m;
    assign ext_m    = (mode == WS_EXTEST) || (mode == WP_EXTEST);
    assign int_m    = (mode == WS_INTEST) || (mode == WP_INTEST);
`ifdef WBR_SAFE_STATE_EN
    assign safe_m   = (mode == WS_SAFE);
`endif

    assign func     = {op_cfi, wfi};
    assign test_sel = {{NUM_OP{ext_m}}, {NUM_IP{int_m}}};

    always_ff @(posedge clk) begin
        if (arst)
            byp <= 1'b0;
        else if (shiftwr && !active)
            byp <= wsi;
    end

    for (genvar k = 0; k < N; k++) begin : g_cell
        // Chain heads take wpi in parallel mode; everything else chains from k-1.
        if (k == 0) begin : g_head0
            assign sin[k] = par_m ? wpi[0] : wsi;
        end else if ((k % L) == 0) begin : g_head
            assign sin[k] = par_m ? wpi[k / L] : s[k-1];
        end else begin : g_body
            assign sin[k] = s[k-1];
        end

        wbr_cell_v2 u_cell (
            .clk        (clk),
            .arst       (arst),
            .capture_en (capturewr && active),
            .shift_en   (shiftwr && active),
            .update_en  (updatewr && active),
            .scan_in    (sin[k]),
            .func_in    (func[k]),
            .test_sel   (test_sel[k]),
`ifdef WBR_SAFE_STATE_EN
            .safe_sel   (safe_m),
            .safe_val   (SAFE_VAL[k]),
`endif
            .s          (s[k]),
            .cell_out   (cell_out[k])
        );
    end

    for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_chain
        if (c * L < N) begin : g_tail
            localparam int unsigned HI = ((c + 1) * L < N) ? (c + 1) * L - 1 : N - 1;
            assign wpo_par[c] = s[HI];
        end else begin : g_empty
            logic pass_q;
            always_ff @(posedge clk) begin
                if (arst)
                    pass_q <= 1'b0;
                else
                    pass_q <= wpi[c];
            end
            assign wpo_par[c] = pass_q;
        end
    end

    assign wso    = serial_m ? s[N-1] : (par_m ? 1'b0 : byp);
    assign wpo    = par_m ? wpo_par : '0;
    assign ip_cfo = cell_out[NUM_IP-1:0];
    assign wfo    = cell_out[N-1:NUM_IP];

endmodule
